// File: rtl/lc3_regfile_cc_if.sv
// lc3_regfile_cc_if: register-file bus; master drives ld_reg/dr/sr1/sr2/bus_in/ld_cc/ld_ben/ir_nzp, slave returns sr1_out/sr2_out/nzp/ben
interface lc3_regfile_cc_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic              ld_reg;
  logic [AW-1:0]     dr;
  logic [AW-1:0]     sr1;
  logic [AW-1:0]     sr2;
  logic [DATA_W-1:0] bus_in;
  logic              ld_cc;
  logic              ld_ben;
  logic [2:0]        ir_nzp;
  logic [DATA_W-1:0] sr1_out;
  logic [DATA_W-1:0] sr2_out;
  logic [2:0]        nzp;
  logic              ben;
  modport master (
    output ld_reg, dr, sr1, sr2, bus_in, ld_cc, ld_ben, ir_nzp,
    input  sr1_out, sr2_out, nzp, ben
  );
  modport slave (
    input  ld_reg, dr, sr1, sr2, bus_in, ld_cc, ld_ben, ir_nzp,
    output sr1_out, sr2_out, nzp, ben
  );
endinterface

// File: rtl/lc3_regfile_cc.sv
// lc3_regfile_cc: LC-3 R0..R7 + NZP + BEN; ports clk, rst (sync high), bus (slave: writes, two comb reads, nzp, ben); REGFILE_BYPASS_EN enables write-first read forwarding
module lc3_regfile_cc #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input logic                clk,
  input logic                rst,
  lc3_regfile_cc_if.slave    bus
);
  logic [DATA_W-1:0] regs [NREG];
  logic [2:0]        nzp_q;
  logic              ben_q;
  logic [2:0]        nzp_d;
  always_comb begin
    nzp_d = {bus.bus_in[DATA_W-1], bus.bus_in == '0, ~bus.bus_in[DATA_W-1] & (|bus.bus_in)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      nzp_q <= 3'b010;
      ben_q <= 1'b0;
    end else begin
      if (bus.ld_reg) regs[bus.dr] <= bus.bus_in;
      if (bus.ld_cc) nzp_q <= nzp_d;
      if (bus.ld_ben) ben_q <= |(bus.ir_nzp & nzp_q);
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign bus.sr1_out = (bus.ld_reg && bus.dr == bus.sr1) ? bus.bus_in : regs[bus.sr1];
  assign bus.sr2_out = (bus.ld_reg && bus.dr == bus.sr2) ? bus.bus_in : regs[bus.sr2];
`else
  assign bus.sr1_out = regs[bus.sr1];
  assign bus.sr2_out = regs[bus.sr2];
`endif
  assign bus.nzp = nzp_q;
  assign bus.ben = ben_q;
endmodule

// File: tb/tb_lc3_regfile_cc.sv
// tb_lc3_regfile_cc: directed self-checking bench for lc3_regfile_cc
`timescale 1ns/1ps
module tb_lc3_regfile_cc;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  lc3_regfile_cc_if #(.DATA_W(16), .AW(3)) rf ();
  lc3_regfile_cc #(.DATA_W(16), .NREG(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    rf.sr1 = a;
    rf.sr2 = b;
    #1;
  endtask
  initial begin
    logic [15:0] bypass_exp;
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 16'hBEEF;
`else
    bypass_exp = 16'h0007;
`endif
    rst = 1'b1;
    rf.ld_reg = 1'b0; rf.dr = '0; rf.sr1 = '0; rf.sr2 = '0; rf.bus_in = '0;
    rf.ld_cc = 1'b0; rf.ld_ben = 1'b0; rf.ir_nzp = '0;
    step();
    rst = 1'b0;
    chk("reset_nzp", {13'd0, rf.nzp}, 16'h0002);
    chk("reset_ben", {15'd0, rf.ben}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(7 - i));
      chk("reset_reg_sr1", rf.sr1_out, 16'h0000);
      chk("reset_reg_sr2", rf.sr2_out, 16'h0000);
    end
    rf.ld_reg = 1'b1; rf.dr = 3'd3; rf.bus_in = 16'h1234;
    step();
    rf.ld_reg = 1'b0;
    rd(3'd3, 3'd3);
    chk("wr3_sr1", rf.sr1_out, 16'h1234);
    chk("wr3_sr2", rf.sr2_out, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        rd(3'(i), 3'd3);
        chk("wr3_other", rf.sr1_out, 16'h0000);
      end
    end
    rf.ld_cc = 1'b1; rf.bus_in = 16'h8000; step();
    chk("cc_neg", {13'd0, rf.nzp}, 16'h0004);
    rf.bus_in = 16'h0000; step();
    chk("cc_zero", {13'd0, rf.nzp}, 16'h0002);
    rf.bus_in = 16'hFFFF; step();
    chk("cc_neg_ffff", {13'd0, rf.nzp}, 16'h0004);
    rf.bus_in = 16'h7FFF; step();
    chk("cc_pos_7fff", {13'd0, rf.nzp}, 16'h0001);
    rf.ld_cc = 1'b0; rf.bus_in = 16'h8000; step();
    chk("cc_hold", {13'd0, rf.nzp}, 16'h0001);
    rf.ld_cc = 1'b1; rf.bus_in = 16'h0001; step();
    chk("cc_pos", {13'd0, rf.nzp}, 16'h0001);
    rf.ld_cc = 1'b1; rf.bus_in = 16'h0000; rf.ld_ben = 1'b1; rf.ir_nzp = 3'b001;
    step();
    chk("ben_old_p", {15'd0, rf.ben}, 16'h0001);
    chk("ben_nzp_after", {13'd0, rf.nzp}, 16'h0002);
    rf.ld_cc = 1'b0; rf.ir_nzp = 3'b001; step();
    chk("ben_miss", {15'd0, rf.ben}, 16'h0000);
    rf.ir_nzp = 3'b110; step();
    chk("ben_hit_z", {15'd0, rf.ben}, 16'h0001);
    rf.ld_ben = 1'b0; rf.ir_nzp = 3'b000; step();
    chk("ben_hold", {15'd0, rf.ben}, 16'h0001);
    rf.ld_reg = 1'b1; rf.dr = 3'd5; rf.bus_in = 16'h0007; step();
    rf.dr = 3'd5; rf.bus_in = 16'hBEEF;
    rd(3'd5, 3'd3);
    chk("bypass_same_cycle", rf.sr1_out, bypass_exp);
    chk("bypass_other_port", rf.sr2_out, 16'h1234);
    step();
    rf.ld_reg = 1'b0;
    #1;
    chk("bypass_next_cycle", rf.sr1_out, 16'hBEEF);
    rf.ld_reg = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rf.dr = 3'(i); rf.bus_in = 16'hA000 + 16'(i * 17);
      step();
    end
    rf.ld_reg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(7 - i), 3'(i));
      chk("all_idx_sr2", rf.sr2_out, 16'hA000 + 16'(i * 17));
      chk("all_idx_sr1", rf.sr1_out, 16'hA000 + 16'((7 - i) * 17));
    end
    rst = 1'b1; rf.ld_reg = 1'b1; rf.dr = 3'd2; rf.bus_in = 16'hFFFF;
    rf.ld_cc = 1'b1; rf.ld_ben = 1'b1; rf.ir_nzp = 3'b111;
    step();
    rst = 1'b0; rf.ld_reg = 1'b0; rf.ld_cc = 1'b0; rf.ld_ben = 1'b0;
    rd(3'd2, 3'd2);
    chk("rst_reg2", rf.sr1_out, 16'h0000);
    chk("rst_nzp", {13'd0, rf.nzp}, 16'h0002);
    chk("rst_ben", {15'd0, rf.ben}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(i));
      chk("rst_all", rf.sr2_out, 16'h0000);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
